sram_req_ctrl: RTL and testbench
================================

SRAM_REQ_CTRL -- requirements
Module: sram_req_ctrl

Interface
REQ-001 SHALL have parameter AW, default 8, meaning the SRAM address width.
REQ-002 SHALL have parameter DW, default 256, meaning the SRAM data width.
REQ-003 SHALL have parameter RSP_DEPTH, default 2, meaning the response-buffer entries (minimum 2).
REQ-004 SHALL have port clock, input, 1 bit, the single clock; all state SHALL be updated on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit; reset is synchronous and active-low.
REQ-006 SHALL have ports req_valid (input, 1) and req_ready (output, 1): the request handshake.
REQ-007 SHALL have ports req_write (input, 1), req_addr (input, AW) and req_wdata (input, DW): the request payload.
REQ-008 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1) and rsp_data (output, DW): the read-response handshake.
REQ-009 SHALL have ports sram_valid, sram_write (outputs, 1), sram_addr (output, AW) and sram_wdata (output, DW): the memory-side command.
REQ-010 SHALL have port sram_rdata, input, DW: the memory-side data, valid in the cycle after a read command and combinational thereafter.
REQ-011 SHALL have port busy, output, 1 bit: high while requests cannot be accepted for a non-flow-control reason (see Configuration).

Function
REQ-012 A request SHALL be accepted in any cycle where req_valid and req_ready are both high.
REQ-013 Command issue SHALL be zero-latency: in the acceptance cycle, sram_valid=1, and sram_write/addr/wdata SHALL equal the req_write/addr/wdata inputs.
REQ-014 sram_valid SHALL be 0 in every cycle with no acceptance (RUN state); sram_write/addr/wdata are don't-care when sram_valid=0.
REQ-015 Writes SHALL be accepted whenever the state is RUN; they produce no response.
REQ-016 Reads SHALL be accepted only while occupancy + inflight - (rsp_valid & rsp_ready) < RSP_DEPTH.
- inflight = 1 in the cycle after a read issue, else 0.
REQ-017 In the cycle after a read issue, sram_rdata SHALL be pushed into the response FIFO unconditionally.
- Space is reserved at issue, so a write to the same address in that cycle cannot corrupt the captured data.
REQ-018 rsp_valid SHALL be high iff the FIFO is non-empty; rsp_data SHALL be the head entry and SHALL stay stable while rsp_valid & ~rsp_ready.
REQ-019 Responses SHALL be returned in request order; minimum read latency is 1 cycle (accept in cycle N, rsp_valid in cycle N+1).
REQ-020 Sustained throughput SHALL be one read per cycle while rsp_ready=1.
REQ-021 Simultaneous push and pop SHALL leave occupancy unchanged; occupancy SHALL never exceed RSP_DEPTH, and pointers wrap modulo RSP_DEPTH.
REQ-022 State machine: INIT -> RUN when init completes; RUN has no exit except reset.

Reset
REQ-023 When reset_n=0 at a rising edge, the block SHALL clear the FIFO, inflight, pointers and occupancy, and enter INIT (macro defined) or RUN (macro undefined).
REQ-024 Output values after reset SHALL be:
- rsp_valid=0, sram_valid=0;
- req_ready=0 and busy=1 in INIT;
- req_ready=1 and busy=0 in RUN.
REQ-025 A reset mid-operation SHALL discard any in-flight read and all buffered responses; no stale response SHALL appear after reset.

Configuration
REQ-026 With SRAM_REQ_CTRL_INIT_EN defined, INIT SHALL write zero to addresses 0..2^AW-1, one per cycle.
- During INIT: sram_valid=1, sram_write=1, req_ready=0, busy=1.
- The transition to RUN SHALL occur after the write to address 2^AW-1, i.e. 2^AW cycles after reset release.
REQ-027 With SRAM_REQ_CTRL_INIT_EN undefined, the INIT state and address counter SHALL be absent, and the block SHALL enter RUN directly from reset with busy tied to 0.

Structure
REQ-028 A shared package sram_req_ctrl_pkg SHALL hold the default AW/DW/RSP_DEPTH constants and the state enum (INIT, RUN).
REQ-029 The response buffer SHALL be a sub-module sram_rsp_fifo (parameters DW, DEPTH; push/pop/occupancy).

Verification
REQ-030 Write 0xA5.. to addr 0x10, then read 0x10 with rsp_ready=1: rsp_valid SHALL rise 1 cycle after the read accept, with rsp_data=0xA5...
REQ-031 Read 0x20 (holding 0x1), then write 0x2 to 0x20 in the next cycle: the response SHALL be 0x1.
REQ-032 Hold rsp_ready=0 and issue 3 reads: the first 2 SHALL be accepted and req_ready SHALL be 0 for the 3rd until one pop occurs.
REQ-033 Issue back-to-back reads of addresses 0..15 with rsp_ready=1: 16 responses SHALL arrive in order on 16 consecutive cycles.
REQ-034 Assert reset_n=0 while the FIFO holds 2 entries: after release, rsp_valid SHALL be 0 and no old data SHALL appear.
REQ-035 With SRAM_REQ_CTRL_INIT_EN defined, release reset:
- busy SHALL stay 1 for 256 cycles;
- a read of 0xFF afterwards SHALL return 0.

Source files
------------

// File: rtl/sram_req_ctrl_pkg.sv
// Shared constants and state encoding for the SRAM request controller.
package sram_req_ctrl_pkg;

  localparam int unsigned DEF_AW        = 8;
  localparam int unsigned DEF_DW        = 256;
  localparam int unsigned DEF_RSP_DEPTH = 2;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Read-response FIFO with fall-through: a push into an empty FIFO is visible
// at the head in the same cycle, so single-cycle read latency is preserved.
module sram_rsp_fifo #(
  parameter int unsigned DW    = 256,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic [DW-1:0]                push_data,
  input  logic                         pop,
  output logic                         valid,
  output logic [DW-1:0]                head,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [OW-1:0] count;
  logic          empty;
  logic          wr_en;
  logic          rd_en;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A push popped straight through an empty FIFO is never stored.
  always_comb begin
    empty     = (count == '0);
    wr_en     = push & ~(empty & pop);
    rd_en     = pop & ~empty;
    valid     = ~empty | push;
    head      = empty ? push_data : mem[rd_ptr];
    occupancy = count;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wrap_inc(wr_ptr);
      if (rd_en) rd_ptr <= wrap_inc(rd_ptr);
      count <= count + OW'(wr_en) - OW'(rd_en);
    end
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sram_req_ctrl.sv
// SRAM request controller: zero-latency command issue, in-order read
// responses through a reserved-space FIFO.
// Optional SRAM_REQ_CTRL_INIT_EN: zero-fill the whole SRAM after reset.
module sram_req_ctrl
  import sram_req_ctrl_pkg::*;
#(
  parameter int unsigned AW        = DEF_AW,
  parameter int unsigned DW        = DEF_DW,
  parameter int unsigned RSP_DEPTH = DEF_RSP_DEPTH
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          sram_valid,
  output logic          sram_write,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata,
  output logic          busy
);

  localparam int unsigned OW = $clog2(RSP_DEPTH + 1);

  logic          in_run;
  logic          accept;
  logic          pop;
  logic          inflight;
  logic          room;
  logic [OW-1:0] occupancy;
  logic [OW:0]   committed;

`ifdef SRAM_REQ_CTRL_INIT_EN
  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] init_addr;
  logic [AW-1:0] init_addr_nxt;

  // State and zero-fill address registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= INIT;
      init_addr <= '0;
    end else begin
      state     <= state_nxt;
      init_addr <= init_addr_nxt;
    end
  end

  // Walk every address once, then run forever.
  always_comb begin
    state_nxt     = state;
    init_addr_nxt = init_addr;
    if (state == INIT) begin
      init_addr_nxt = init_addr + AW'(1);
      if (init_addr == '1) state_nxt = RUN;
    end
  end

  assign in_run = (state == RUN);
  assign busy   = ~in_run;
`else
  assign in_run = 1'b1;
  assign busy   = 1'b0;
`endif

  // Reads need a free slot counting the in-flight read and this cycle's pop.
  always_comb begin
    pop       = rsp_valid & rsp_ready;
    committed = {1'b0, occupancy} + (OW+1)'(inflight) - (OW+1)'(pop);
    room      = committed < (OW+1)'(RSP_DEPTH);
  end

  // Handshake and memory command; requests pass straight through to the SRAM.
  always_comb begin
    req_ready  = in_run & (req_write | room);
    accept     = req_valid & req_ready;
    sram_valid = accept;
    sram_write = req_write;
    sram_addr  = req_addr;
    sram_wdata = req_wdata;
`ifdef SRAM_REQ_CTRL_INIT_EN
    if (state == INIT) begin
      sram_valid = 1'b1;
      sram_write = 1'b1;
      sram_addr  = init_addr;
      sram_wdata = '0;
    end
`endif
  end

  // Marks the cycle in which read data is returned by the SRAM.
  always_ff @(posedge clock) begin
    if (!reset_n) inflight <= 1'b0;
    else          inflight <= accept & ~req_write;
  end

  sram_rsp_fifo #(
    .DW    (DW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (inflight),
    .push_data (sram_rdata),
    .pop       (pop),
    .valid     (rsp_valid),
    .head      (rsp_data),
    .occupancy (occupancy)
  );

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed bench for sram_req_ctrl with a behavioural one-cycle SRAM model.
module tb_sram_req_ctrl;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 256;

  logic          clock;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          sram_valid;
  logic          sram_write;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
  logic          busy;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] mem [256];
  logic [DW-1:0] a5_word;

  sram_req_ctrl #(.AW(AW), .DW(DW), .RSP_DEPTH(2)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .sram_valid (sram_valid),
    .sram_write (sram_write),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // SRAM model: read data registered on the command edge and held afterwards.
  always @(posedge clock) begin
    if (sram_valid) begin
      if (sram_write) mem[sram_addr] <= sram_wdata;
      else            sram_rdata     <= mem[sram_addr];
    end
  end

  function automatic logic [DW-1:0] pat(input int i);
    return {8{32'h5A00_0000 | 32'(i)}};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic drive(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
  endtask

  // Called in the first cycle after reset release.
  task automatic wait_init();
`ifdef SRAM_REQ_CTRL_INIT_EN
    for (int i = 0; i < 256; i++) begin
      mid();
      chk("init_busy", busy, 1'b1);
      chk("init_ready", req_ready, 1'b0);
      chk("init_sram_valid", sram_valid, 1'b1);
      chk("init_sram_write", sram_write, 1'b1);
      chk("init_addr", sram_addr, DW'(i));
      chk("init_wdata", sram_wdata, '0);
      cyc();
    end
`endif
    mid();
    chk("run_busy", busy, 1'b0);
    chk("run_ready", req_ready, 1'b1);
  endtask

  initial begin
    a5_word   = {32{8'hA5}};
    reset_n   = 1'b0;
    rsp_ready = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clock);
    #1;

    // Reset state
    mid();
    chk("rst_rsp_valid", rsp_valid, 1'b0);
`ifdef SRAM_REQ_CTRL_INIT_EN
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_busy", busy, 1'b1);
`else
    chk("rst_sram_valid", sram_valid, 1'b0);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
`endif
    cyc();
    reset_n = 1'b1;
    wait_init();
    cyc();

    // Write A5 to 0x10, read it back with one-cycle latency
    rsp_ready = 1'b1;
    drive(1'b1, 1'b1, 8'h10, a5_word);
    mid();
    chk("wr_ready", req_ready, 1'b1);
    chk("wr_sram_valid", sram_valid, 1'b1);
    chk("wr_sram_write", sram_write, 1'b1);
    chk("wr_sram_addr", sram_addr, DW'(8'h10));
    chk("wr_sram_wdata", sram_wdata, a5_word);
    cyc();
    drive(1'b1, 1'b0, 8'h10, '0);
    mid();
    chk("rd_sram_valid", sram_valid, 1'b1);
    chk("rd_sram_write", sram_write, 1'b0);
    chk("rd_sram_addr", sram_addr, DW'(8'h10));
    chk("rd_no_rsp_yet", rsp_valid, 1'b0);
    cyc();
    drive(1'b0, 1'b0, '0, '0);
    mid();
    chk("rd_rsp_valid", rsp_valid, 1'b1);
    chk("rd_rsp_data", rsp_data, a5_word);
    chk("idle_sram_valid", sram_valid, 1'b0);
    cyc();
    mid();
    chk("rd_rsp_drained", rsp_valid, 1'b0);
    cyc();

    // Read 0x20 then overwrite it in the next cycle; response keeps old value
    drive(1'b1, 1'b1, 8'h20, DW'(1));
    cyc();
    rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h20, '0);
    mid();
    chk("raw_rd_ready", req_ready, 1'b1);
    cyc();
    drive(1'b1, 1'b1, 8'h20, DW'(2));
    mid();
    chk("raw_wr_ready", req_ready, 1'b1);
    chk("raw_rsp_valid", rsp_valid, 1'b1);
    chk("raw_rsp_data", rsp_data, DW'(1));
    cyc();
    drive(1'b0, 1'b0, '0, '0);
    mid();
    chk("raw_hold_valid", rsp_valid, 1'b1);
    chk("raw_hold_data", rsp_data, DW'(1));
    cyc();
    rsp_ready = 1'b1;
    mid();
    chk("raw_pop_data", rsp_data, DW'(1));
    cyc();
    mid();
    chk("raw_drained", rsp_valid, 1'b0);
    cyc();

    // Fill 0..15, then stream 16 reads back-to-back
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, AW'(i), pat(i));
      cyc();
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, AW'(i), '0);
      mid();
      chk("stream_ready", req_ready, 1'b1);
      if (i > 0) begin
        chk("stream_valid", rsp_valid, 1'b1);
        chk("stream_data", rsp_data, pat(i - 1));
      end
      cyc();
    end
    drive(1'b0, 1'b0, '0, '0);
    mid();
    chk("stream_last_valid", rsp_valid, 1'b1);
    chk("stream_last_data", rsp_data, pat(15));
    cyc();
    mid();
    chk("stream_drained", rsp_valid, 1'b0);
    cyc();

    // Backpressure: two reads fill the buffer, the third waits for a pop
    rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h10, '0);
    mid();
    chk("bp_rd1_ready", req_ready, 1'b1);
    cyc();
    drive(1'b1, 1'b0, 8'h20, '0);
    mid();
    chk("bp_rd2_ready", req_ready, 1'b1);
    chk("bp_head_valid", rsp_valid, 1'b1);
    chk("bp_head_data", rsp_data, a5_word);
    cyc();
    drive(1'b1, 1'b0, 8'h05, '0);
    mid();
    chk("bp_rd3_blocked", req_ready, 1'b0);
    chk("bp_rd3_no_cmd", sram_valid, 1'b0);
    chk("bp_head_stable", rsp_data, a5_word);
    cyc();
    drive(1'b1, 1'b1, 8'h40, pat(64));
    mid();
    chk("bp_full_wr_ready", req_ready, 1'b1);
    chk("bp_full_wr_cmd", sram_write, 1'b1);
    chk("bp_full_valid", rsp_valid, 1'b1);
    chk("bp_full_data", rsp_data, a5_word);
    cyc();
    drive(1'b1, 1'b0, 8'h05, '0);
    rsp_ready = 1'b1;
    mid();
    chk("bp_rd3_on_pop", req_ready, 1'b1);
    chk("bp_pop1_data", rsp_data, a5_word);
    cyc();
    drive(1'b0, 1'b0, '0, '0);
    mid();
    chk("bp_pop2_valid", rsp_valid, 1'b1);
    chk("bp_pop2_data", rsp_data, DW'(2));
    cyc();
    mid();
    chk("bp_pop3_valid", rsp_valid, 1'b1);
    chk("bp_pop3_data", rsp_data, pat(5));
    cyc();
    mid();
    chk("bp_drained", rsp_valid, 1'b0);
    cyc();

    // Reset with two buffered responses; none may survive
    rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h00, '0);
    cyc();
    drive(1'b1, 1'b0, 8'h01, '0);
    cyc();
    drive(1'b0, 1'b0, '0, '0);
    cyc();
    reset_n = 1'b0;
    mid();
    chk("prerst_valid", rsp_valid, 1'b1);
    chk("prerst_data", rsp_data, pat(0));
    cyc();
    reset_n = 1'b1;
    mid();
    chk("postrst_valid", rsp_valid, 1'b0);
    wait_init();
    rsp_ready = 1'b1;
    chk("postrst_valid2", rsp_valid, 1'b0);
    cyc();
    mid();
    chk("postrst_valid3", rsp_valid, 1'b0);
    chk("postrst_idle_cmd", sram_valid, 1'b0);
    cyc();

`ifdef SRAM_REQ_CTRL_INIT_EN
    // Top address was zero-filled
    drive(1'b1, 1'b0, 8'hFF, '0);
    mid();
    chk("init_rd_ready", req_ready, 1'b1);
    cyc();
    drive(1'b0, 1'b0, '0, '0);
    mid();
    chk("init_rd_valid", rsp_valid, 1'b1);
    chk("init_rd_data", rsp_data, '0);
    cyc();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
